// File: rtl/monolith_pkg.sv
// Shared types for the monolith job sequencer: field-element type, FSM states,
// the queued job record and the canonical-reduction helper.
package monolith_pkg;

  localparam bit [30:0] P31       = 31'h7FFF_FFFF;
  // Tag field is sized for the widest supported TAG_W; users narrow it by cast.
  localparam int        MAX_TAG_W = 16;

  typedef bit [30:0] felt_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    RUN,
    DONE
  } job_state_e;

  typedef struct packed {
    felt_t                in1;
    felt_t                in2;
    logic                 mode;
    logic [MAX_TAG_W-1:0] tag;
  } job_t;

  // p itself is the only non-canonical 31-bit encoding of a residue mod p.
  function automatic felt_t canon(input felt_t x);
    return (x == P31) ? felt_t'(0) : x;
  endfunction

endpackage

// File: rtl/monolith_job_fifo.sv
// Synchronous request FIFO of job_t records, depth 2^AW, with count-based
// full/empty flags taken from the registered occupancy.
module monolith_job_fifo
  import monolith_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  job_t wdata_i,
  input  logic pop_i,
  output job_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int DEPTH = 1 << AW;

  job_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Occupancy never exceeds DEPTH, so its top bit alone flags full.
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; flushing the pointers and count empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/monolith_job_ctrl.sv
// Upstream sequencer for monolith_top: queues jobs, runs them one at a time on
// the engine under a watchdog, and returns digest plus tag on a response port.
module monolith_job_ctrl
  import monolith_pkg::*;
#(
  parameter int FIFO_AW     = 2,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [30:0]      req_in1,
  input  logic [30:0]      req_in2,
  input  logic             req_mode,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [30:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic [30:0]      eng_in1,
  output logic [30:0]      eng_in2,
  output logic             eng_mode,
  output logic             eng_go,
  input  logic [30:0]      eng_out,
  input  logic             eng_valid,
  output logic             busy,
  output logic [15:0]      jobs_done
);

  job_state_e       state_q, state_d;
  job_t             req_job, head;
  logic             fifo_full, fifo_empty;
  logic             pop, wdog_expired;
  logic             run_done, wdog_clr, rsp_load, eng_go_d;

  logic [30:0]      eng_in1_q, eng_in2_q, res_data_q, rsp_data_q;
  logic             eng_mode_q, eng_go_q, res_timeout_q, rsp_valid_q, rsp_timeout_q;
  logic [TAG_W-1:0] job_tag_q, rsp_tag_q;
  logic [15:0]      wdog_q, jobs_done_q;

  assign req_job = '{in1: req_in1, in2: req_in2, mode: req_mode, tag: MAX_TAG_W'(req_tag)};

  monolith_job_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (req_valid),
    .wdata_i (req_job),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A new job starts only once the previous response has been taken.
  assign pop          = (state_q == IDLE) && !fifo_empty && !rsp_valid_q;
  assign wdog_expired = (wdog_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = LOAD0;
      LOAD0:   state_d = LOAD1;
      LOAD1:   state_d = RUN;
      RUN:     if (eng_valid || wdog_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // go follows the next state through a flop, so it is high exactly while in RUN.
  always_comb begin
    wdog_clr = (state_q == LOAD1);
    run_done = (state_q == RUN) && (eng_valid || wdog_expired);
    rsp_load = (state_q == DONE);
    eng_go_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_in1_q     <= '0;
      eng_in2_q     <= '0;
      eng_mode_q    <= 1'b0;
      eng_go_q      <= 1'b0;
      job_tag_q     <= '0;
      wdog_q        <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
      jobs_done_q   <= '0;
    end else begin
      eng_go_q <= eng_go_d;
      if (pop) begin
        eng_in1_q  <= canon(head.in1);
        eng_in2_q  <= head.mode ? canon(head.in2) : '0;
        eng_mode_q <= head.mode;
        job_tag_q  <= TAG_W'(head.tag);
      end
      if (wdog_clr) begin
        wdog_q <= '0;
      end else if (state_q == RUN) begin
        wdog_q <= wdog_q + 16'd1;
      end
      // A result arriving on the expiry cycle still counts as a completion.
      if (run_done) begin
        res_data_q    <= eng_valid ? eng_out : '0;
        res_timeout_q <= !eng_valid;
      end
      if (rsp_load) begin
        rsp_valid_q   <= 1'b1;
        rsp_data_q    <= res_data_q;
        rsp_tag_q     <= job_tag_q;
        rsp_timeout_q <= res_timeout_q;
        jobs_done_q   <= jobs_done_q + 16'd1;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign req_ready   = !fifo_full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_timeout = rsp_timeout_q;
  assign eng_in1     = eng_in1_q;
  assign eng_in2     = eng_in2_q;
  assign eng_mode    = eng_mode_q;
  assign eng_go      = eng_go_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign jobs_done   = jobs_done_q;

endmodule

// File: tb/tb_monolith_job_ctrl.sv
// Directed bench for monolith_job_ctrl with a behavioural engine whose latency
// is adjustable; digest = in1 + 2*in2 + (mode ? 1000 : 0) + 17 (mod 2^31).
module tb_monolith_job_ctrl;

  localparam int          TAG_W = 4;
  localparam logic [30:0] P     = 31'h7FFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [30:0]      req_in1 = '0;
  logic [30:0]      req_in2 = '0;
  logic             req_mode = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [30:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic [30:0]      eng_in1, eng_in2;
  logic             eng_mode, eng_go;
  logic [30:0]      eng_out = '0;
  logic             eng_valid = 1'b0;
  logic             busy;
  logic [15:0]      jobs_done;

  int errors = 0;
  int checks = 0;
  int eng_lat = 3;
  int eng_cnt = 0;
  int go_total = 0;

  typedef struct {
    logic [30:0]      data;
    logic [TAG_W-1:0] tag;
    logic             timeout;
  } rsp_t;
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  monolith_job_ctrl #(
    .FIFO_AW     (2),
    .TAG_W       (TAG_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .req_mode    (req_mode),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .rsp_timeout (rsp_timeout),
    .eng_in1     (eng_in1),
    .eng_in2     (eng_in2),
    .eng_mode    (eng_mode),
    .eng_go      (eng_go),
    .eng_out     (eng_out),
    .eng_valid   (eng_valid),
    .busy        (busy),
    .jobs_done   (jobs_done)
  );

  function automatic logic [30:0] eng_fn(input logic [30:0] a, input logic [30:0] b, input logic m);
    logic [63:0] s;
    s = 64'(a) + 2 * 64'(b) + (m ? 64'd1000 : 64'd0) + 64'd17;
    return s[30:0];
  endfunction

  // Engine held in reset while go is low; result appears eng_lat cycles into RUN.
  always @(posedge clk) begin
    if (!eng_go) begin
      eng_valid <= 1'b0;
      eng_cnt   <= 0;
    end else if (!eng_valid) begin
      if (eng_cnt == eng_lat - 1) begin
        eng_valid <= 1'b1;
        eng_out   <= eng_fn(eng_in1, eng_in2, eng_mode);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (eng_go) go_total++;
    if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_data, rsp_tag, rsp_timeout});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [30:0] a, input logic [30:0] b, input logic m,
                      input logic [TAG_W-1:0] t);
    int k;
    k = 0;
    req_in1 = a; req_in2 = b; req_mode = m; req_tag = t; req_valid = 1'b1;
    while (!req_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("push_stall", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_go(input string name);
    int k;
    k = 0;
    while (!eng_go && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!eng_go) check({name, "_go_wait"}, 0, 1);
  endtask

  task automatic wait_rsps(input string name, input int n);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() < n) check({name, "_rsp_wait"}, 0, 1);
  endtask

  task automatic expect_rsp(input string name, input logic [30:0] d,
                            input logic [TAG_W-1:0] t, input logic to);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      check({name, "_missing"}, 0, 1);
    end else begin
      r = rsp_q.pop_front();
      check({name, "_data"}, r.data, d);
      check({name, "_tag"}, r.tag, t);
      check({name, "_timeout"}, r.timeout, to);
    end
  endtask

  initial begin
    int g0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_go", eng_go, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);

    // 1: HASH with nonzero in2, which must be forced to 0
    rsp_ready = 1'b1;
    g0 = go_total;
    push(31'd5, 31'd9, 1'b0, 4'd3);
    wait_go("t1");
    check("t1_eng_in1", eng_in1, 5);
    check("t1_eng_in2", eng_in2, 0);
    check("t1_eng_mode", eng_mode, 0);
    wait_rsps("t1", 1);
    expect_rsp("t1", 31'd22, 4'd3, 1'b0);
    check("t1_jobs_done", jobs_done, 1);
    check("t1_go_cycles", go_total - g0, 4);

    // 2: back-to-back COMPRESS then HASH
    push(31'd1, 31'd2, 1'b1, 4'd5);
    push(31'd7, 31'd0, 1'b0, 4'd6);
    wait_rsps("t2", 2);
    expect_rsp("t2a", 31'd1022, 4'd5, 1'b0);
    expect_rsp("t2b", 31'd24, 4'd6, 1'b0);
    check("t2_jobs_done", jobs_done, 3);

    // 4: canonical reduction of p on both inputs
    push(P, 31'd0, 1'b0, 4'd1);
    wait_go("t4a");
    check("t4a_eng_in1", eng_in1, 0);
    wait_rsps("t4a", 1);
    expect_rsp("t4a", 31'd17, 4'd1, 1'b0);
    push(31'd0, 31'd0, 1'b0, 4'd2);
    wait_rsps("t4b", 1);
    expect_rsp("t4b", 31'd17, 4'd2, 1'b0);
    push(31'd4, P, 1'b1, 4'd7);
    wait_go("t4c");
    check("t4c_eng_in2", eng_in2, 0);
    wait_rsps("t4c", 1);
    expect_rsp("t4c", 31'd1021, 4'd7, 1'b0);
    check("t4_jobs_done", jobs_done, 6);

    // 3: fill the FIFO behind a stalled response, then drain in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(31'(10 + i), 31'd0, 1'b0, 4'(8 + i));
    begin
      int k;
      k = 0;
      while (!rsp_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("t3_rsp_valid", rsp_valid, 1);
    req_in1 = 31'd99; req_in2 = 31'd0; req_mode = 1'b0; req_tag = 4'd13; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_req_ready_full", req_ready, 0);
    check("t3_busy", busy, 1);
    check("t3_hold_data", rsp_data, 27);
    check("t3_hold_tag", rsp_tag, 8);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsps("t3", 5);
    for (int i = 0; i < 5; i++) expect_rsp("t3", 31'(27 + i), 4'(8 + i), 1'b0);
    repeat (20) @(negedge clk);
    check("t3_no_extra_rsp", rsp_q.size(), 0);
    check("t3_jobs_done", jobs_done, 11);

    // 5: watchdog expiry, valid-on-expiry boundary, one past, then normal
    eng_lat = 1000;
    g0 = go_total;
    push(31'd3, 31'd0, 1'b0, 4'd4);
    wait_rsps("t5a", 1);
    expect_rsp("t5a", 31'd0, 4'd4, 1'b1);
    check("t5a_go_cycles", go_total - g0, 16);
    eng_lat = 15;
    g0 = go_total;
    push(31'd3, 31'd0, 1'b0, 4'd9);
    wait_rsps("t5b", 1);
    expect_rsp("t5b", 31'd20, 4'd9, 1'b0);
    check("t5b_go_cycles", go_total - g0, 16);
    eng_lat = 16;
    push(31'd5, 31'd0, 1'b0, 4'd10);
    wait_rsps("t5c", 1);
    expect_rsp("t5c", 31'd0, 4'd10, 1'b1);
    eng_lat = 3;
    push(31'd8, 31'd0, 1'b0, 4'd11);
    wait_rsps("t5d", 1);
    expect_rsp("t5d", 31'd25, 4'd11, 1'b0);
    check("t5_jobs_done", jobs_done, 15);

    // 6: reset asserted during RUN with jobs still queued
    eng_lat = 1000;
    push(31'd1, 31'd0, 1'b0, 4'd1);
    push(31'd2, 31'd0, 1'b0, 4'd2);
    push(31'd3, 31'd0, 1'b0, 4'd3);
    wait_go("t6");
    #1 rst_n = 1'b0;
    #1;
    check("t6_eng_go", eng_go, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_jobs_done", jobs_done, 0);
    check("t6_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    eng_lat = 3;
    repeat (30) @(negedge clk);
    check("t6_flushed_rsps", rsp_q.size(), 0);
    check("t6_flushed_busy", busy, 0);
    push(31'd2, 31'd0, 1'b0, 4'd3);
    wait_rsps("t6_after", 1);
    expect_rsp("t6_after", 31'd19, 4'd3, 1'b0);
    check("t6_after_jobs_done", jobs_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

endmodule
